poly_voice_alloc: RTL and testbench
===================================

POLY_VOICE_ALLOC -- requirements
Module: poly_voice_alloc

Interface
REQ-001 SHALL have parameter NOTE_BASE, default 36, meaning the MIDI note mapped to tuning ROM address 0.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port ev_valid  in  1  note event present.
REQ-005 SHALL have port ev_ready  out  1  event accepted when ev_valid&ev_ready sampled high.
REQ-006 SHALL have port ev_on  in  1  1 = note-on, 0 = note-off.
REQ-007 SHALL have port ev_note  in  7  MIDI note number.
REQ-008 SHALL have port all_off  in  1  panic: release all voices.
REQ-009 SHALL have port rom_addr  out  6  tuning ROM address (combinational ROM, 64 x 11).
REQ-010 SHALL have port rom_data  in  11  waveguide length for rom_addr.
REQ-011 SHALL have port len_wr  out  1  one-cycle write strobe for a voice's waveguide length.
REQ-012 SHALL have port len_voice  out  3  voice index for len_wr.
REQ-013 SHALL have port len_val  out  11  waveguide length for len_wr.
REQ-014 SHALL have port gate  out  8  per-voice sounding flag.
REQ-015 SHALL have port pluck  out  8  per-voice one-cycle excitation pulse.

Function
REQ-016 SHALL implement states IDLE, SCAN, ROM, WRITE; ev_ready = 1 only in IDLE.
REQ-017 SHALL register ev_on and ev_note on acceptance edge k (IDLE->SCAN).
REQ-018 SHALL treat an event as in range when NOTE_BASE <= ev_note <= NOTE_BASE+63; rom index = ev_note - NOTE_BASE (6 bits).
REQ-019 SHALL keep per-voice 6-bit note register; a voice "holds" a note when gate bit set and note register matches.
REQ-020 Note-on voice choice, priority order: voice already holding the note (retrigger); else lowest-index voice with gate=0; else voice at steal_ptr.
REQ-021 SHALL advance 3-bit steal_ptr by 1 (wrap 7->0) only when a voice is stolen.
REQ-022 Note-on: edge k+1 SCAN->ROM, chosen voice and rom_addr registered; rom_addr stable throughout ROM.
REQ-023 Note-on: edge k+2 ROM->WRITE, len_val <= rom_data, len_voice <= voice, len_wr <= 1, pluck[voice] <= 1, gate[voice] <= 1, note register <= index.
REQ-024 Note-on: edge k+3 WRITE->IDLE, len_wr and pluck return to 0; ev_ready high from k+3; throughput one note-on per 4 cycles.
REQ-025 Note-off: edge k+1 SCAN->IDLE, gate cleared for the voice holding the note; no len_wr, no pluck; no action if no voice holds it.
REQ-026 Out-of-range event: edge k+1 SCAN->IDLE, no state change besides FSM.
REQ-027 len_wr and pluck SHALL never be high for more than one consecutive cycle; pluck SHALL be one-hot or zero.
REQ-028 all_off sampled high in any state SHALL on that edge clear all gate bits, len_wr and pluck, and force IDLE; an in-flight event is dropped with no len_wr.
REQ-029 len_val and len_voice SHALL hold their last values between writes.

Reset
REQ-030 reset sampled high SHALL force IDLE, gate=0, pluck=0, len_wr=0, len_val=0, len_voice=0, rom_addr=0, steal_ptr=0, all note registers=0, regardless of state; reset has priority over all_off and events.
REQ-031 ev_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 After reset, note-on 36 accepted at edge k -> rom_addr=0 after k+1, len_wr=1/len_voice=0/len_val=rom_data(0)/pluck=8'h01/gate=8'h01 between k+2 and k+3, ev_ready back at k+3.
REQ-033 Note-ons 40..47 back to back, then note-on 50 -> voices 0..7 filled in order, note 50 steals voice 0 (pluck=8'h01), next steal voice 1.
REQ-034 gate=8'h03 holding 40 (v0), 41 (v1); note-off 41 -> gate=8'h01 one edge after SCAN, no len_wr; note-off 99 -> no change.
REQ-035 Note-on 40 while v2 holds 40 and v0 free -> retrigger v2 (len_voice=2, pluck=8'h04), steal_ptr unchanged.
REQ-036 all_off asserted in ROM state during note-on -> gate=0, no len_wr, IDLE next cycle; reset asserted in WRITE -> all outputs zero next cycle.

Source files
------------

// File: rtl/poly_voice_alloc.sv
// Polyphonic voice allocator for an 8-voice waveguide synth.
// Accepts note-on/off events, picks a voice (retrigger, free, or steal),
// looks up the waveguide length in an external tuning ROM and writes it
// to the chosen voice together with a one-cycle pluck pulse.
module poly_voice_alloc #(
  parameter int NOTE_BASE = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic        ev_on,
  input  logic [6:0]  ev_note,
  input  logic        all_off,
  output logic [5:0]  rom_addr,
  input  logic [10:0] rom_data,
  output logic        len_wr,
  output logic [2:0]  len_voice,
  output logic [10:0] len_val,
  output logic [7:0]  gate,
  output logic [7:0]  pluck
);

  typedef enum logic [1:0] {IDLE, SCAN, ROM, WRITE} state_t;

  state_t      state;
  state_t      state_next;
  logic        ev_on_q;
  logic [6:0]  ev_note_q;
  logic [5:0]  note_reg [8];
  logic [2:0]  steal_ptr;
  logic [2:0]  voice_q;
  logic        steal_q;

  logic        in_range;
  logic [5:0]  note_idx;
  logic [7:0]  hold;
  logic        hold_found;
  logic [2:0]  hold_voice;
  logic        free_found;
  logic [2:0]  free_voice;
  logic [2:0]  chosen_voice;
  logic        chosen_steal;

  assign ev_ready = (state == IDLE);

  // Range test and ROM index for the registered event; the 8-bit compare
  // keeps NOTE_BASE+63 from wrapping for bases near the top of MIDI.
  always_comb begin
    in_range = ({1'b0, ev_note_q} >= 8'(NOTE_BASE)) &&
               ({1'b0, ev_note_q} <= 8'(NOTE_BASE + 63));
    note_idx = 6'(ev_note_q - 7'(NOTE_BASE));
  end

  // Voice selection: a voice already holding the note wins, then the
  // lowest-index free voice, otherwise the voice at the steal pointer.
  always_comb begin
    hold         = '0;
    hold_found   = 1'b0;
    hold_voice   = '0;
    free_found   = 1'b0;
    free_voice   = '0;
    chosen_voice = steal_ptr;
    chosen_steal = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hold[i] = gate[i] && (note_reg[i] == note_idx);
      if (hold[i]) begin
        hold_found = 1'b1;
        hold_voice = 3'(i);
      end
      if (!gate[i]) begin
        free_found = 1'b1;
        free_voice = 3'(i);
      end
    end
    if (hold_found) begin
      chosen_voice = hold_voice;
      chosen_steal = 1'b0;
    end else if (free_found) begin
      chosen_voice = free_voice;
      chosen_steal = 1'b0;
    end
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; panic drops any in-flight event back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (ev_valid) state_next = SCAN;
      SCAN:  state_next = (in_range && ev_on_q) ? ROM : IDLE;
      ROM:   state_next = WRITE;
      WRITE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (all_off) state_next = IDLE;
  end

  // Datapath: event capture, voice bookkeeping and the length-write strobe.
  // Strobes default low every cycle so they can only ever last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      gate      <= '0;
      pluck     <= '0;
      len_wr    <= 1'b0;
      len_val   <= '0;
      len_voice <= '0;
      rom_addr  <= '0;
      steal_ptr <= '0;
      voice_q   <= '0;
      steal_q   <= 1'b0;
      for (int i = 0; i < 8; i++) note_reg[i] <= '0;
    end else if (all_off) begin
      gate   <= '0;
      pluck  <= '0;
      len_wr <= 1'b0;
    end else begin
      len_wr <= 1'b0;
      pluck  <= '0;
      case (state)
        IDLE: begin
          if (ev_valid) begin
            ev_on_q   <= ev_on;
            ev_note_q <= ev_note;
          end
        end
        SCAN: begin
          if (in_range && ev_on_q) begin
            voice_q  <= chosen_voice;
            steal_q  <= chosen_steal;
            rom_addr <= note_idx;
          end else if (in_range) begin
            gate <= gate & ~hold;
          end
        end
        ROM: begin
          len_val             <= rom_data;
          len_voice           <= voice_q;
          len_wr              <= 1'b1;
          pluck               <= 8'(1) << voice_q;
          gate[voice_q]       <= 1'b1;
          note_reg[voice_q]   <= rom_addr;
          if (steal_q) steal_ptr <= steal_ptr + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_alloc.sv
// Scoreboard bench for poly_voice_alloc: stimulus pushes the expected
// length writes, a negedge monitor pops and compares them.
module tb_poly_voice_alloc;

  logic        clk = 1'b0;
  logic        reset;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic        all_off;
  logic [5:0]  rom_addr;
  logic [10:0] rom_data;
  logic        len_wr;
  logic [2:0]  len_voice;
  logic [10:0] len_val;
  logic [7:0]  gate;
  logic [7:0]  pluck;

  typedef struct {
    logic [2:0]  voice;
    logic [10:0] val;
    logic [7:0]  pluck;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_wr = 1'b0;

  poly_voice_alloc #(.NOTE_BASE(36)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .all_off(all_off),
    .rom_addr(rom_addr), .rom_data(rom_data), .len_wr(len_wr),
    .len_voice(len_voice), .len_val(len_val), .gate(gate), .pluck(pluck)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic logic [10:0] rom_model(input int idx);
    return 11'(100 + 13 * idx);
  endfunction

  // Combinational tuning ROM model.
  assign rom_data = rom_model(int'(rom_addr));

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every length write must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (len_wr) begin
      checkOutput("len_wr_single_cycle", int'(prev_wr), 0);
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_len_wr", 1, 0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("len_voice", int'(len_voice), int'(e.voice));
        checkOutput("len_val", int'(len_val), int'(e.val));
        checkOutput("pluck", int'(pluck), int'(e.pluck));
        checkOutput("gate_of_written_voice", int'(gate[len_voice]), 1);
      end
    end
    prev_wr = len_wr;
  end

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    @(negedge clk);
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) checkOutput(name, 0, 1);
  endtask

  // Drive one event and return 1 time unit after the acceptance edge.
  task automatic acceptEvent(input logic on, input logic [6:0] note);
    waitReady("ev_ready_timeout");
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    @(posedge clk);
    #1 ev_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic on, input logic [6:0] note, input bit exp_wr,
                               input logic [2:0] voice, input int idx);
    exp_t e;
    if (exp_wr) begin
      e.voice = voice;
      e.val   = rom_model(idx);
      e.pluck = 8'(1) << voice;
      sb_q.push_back(e);
    end
    acceptEvent(on, note);
  endtask

  task automatic waitIdle();
    waitReady("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic panic();
    @(negedge clk);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    exp_t e;
    reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; all_off = 1'b0;
    resetDut();
    @(negedge clk);
    checkOutput("rst_ev_ready", int'(ev_ready), 1);
    checkOutput("rst_gate", int'(gate), 0);
    checkOutput("rst_pluck", int'(pluck), 0);
    checkOutput("rst_len_wr", int'(len_wr), 0);
    checkOutput("rst_len_val", int'(len_val), 0);
    checkOutput("rst_len_voice", int'(len_voice), 0);
    checkOutput("rst_rom_addr", int'(rom_addr), 0);

    // First note-on with cycle-exact timing.
    e.voice = 3'd0; e.val = rom_model(0); e.pluck = 8'h01;
    sb_q.push_back(e);
    acceptEvent(1'b1, 7'd36);
    @(posedge clk); #1;
    checkOutput("k1_rom_addr", int'(rom_addr), 0);
    checkOutput("k1_ev_ready", int'(ev_ready), 0);
    @(posedge clk); #1;
    checkOutput("k2_len_wr", int'(len_wr), 1);
    checkOutput("k2_pluck", int'(pluck), 'h01);
    checkOutput("k2_gate", int'(gate), 'h01);
    checkOutput("k2_len_val", int'(len_val), int'(rom_model(0)));
    @(posedge clk); #1;
    checkOutput("k3_ev_ready", int'(ev_ready), 1);
    checkOutput("k3_len_wr", int'(len_wr), 0);
    checkOutput("k3_pluck", int'(pluck), 0);
    waitIdle();
    panic();
    checkOutput("panic_gate", int'(gate), 0);

    // Fill all voices, then steal twice.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 7'(40 + i), 1'b1, 3'(i), 4 + i);
    waitIdle();
    checkOutput("fill_gate", int'(gate), 'hff);
    applyStimulus(1'b1, 7'd50, 1'b1, 3'd0, 14);
    applyStimulus(1'b1, 7'd51, 1'b1, 3'd1, 15);
    waitIdle();
    checkOutput("steal_gate", int'(gate), 'hff);

    // Note-off behaviour.
    resetDut();
    applyStimulus(1'b1, 7'd40, 1'b1, 3'd0, 4);
    applyStimulus(1'b1, 7'd41, 1'b1, 3'd1, 5);
    waitIdle();
    checkOutput("off_pre_gate", int'(gate), 'h03);
    acceptEvent(1'b0, 7'd41);
    @(posedge clk); #1;
    checkOutput("off_gate", int'(gate), 'h01);
    checkOutput("off_ev_ready", int'(ev_ready), 1);
    applyStimulus(1'b0, 7'd99, 1'b0, 3'd0, 0);
    waitIdle();
    checkOutput("off_unheld_gate", int'(gate), 'h01);

    // Retrigger keeps steal pointer untouched.
    resetDut();
    applyStimulus(1'b1, 7'd38, 1'b1, 3'd0, 2);
    applyStimulus(1'b1, 7'd39, 1'b1, 3'd1, 3);
    applyStimulus(1'b1, 7'd40, 1'b1, 3'd2, 4);
    applyStimulus(1'b0, 7'd38, 1'b0, 3'd0, 0);
    waitIdle();
    checkOutput("retrig_pre_gate", int'(gate), 'h06);
    applyStimulus(1'b1, 7'd40, 1'b1, 3'd2, 4);
    waitIdle();
    checkOutput("retrig_gate", int'(gate), 'h06);
    applyStimulus(1'b1, 7'd60, 1'b1, 3'd0, 24);
    for (int i = 3; i < 8; i++) applyStimulus(1'b1, 7'(58 + i), 1'b1, 3'(i), 22 + i);
    applyStimulus(1'b1, 7'd66, 1'b1, 3'd0, 30);
    waitIdle();
    checkOutput("retrig_fill_gate", int'(gate), 'hff);

    // Range boundaries.
    resetDut();
    applyStimulus(1'b1, 7'd99, 1'b1, 3'd0, 63);
    applyStimulus(1'b1, 7'd100, 1'b0, 3'd0, 0);
    applyStimulus(1'b1, 7'd35, 1'b0, 3'd0, 0);
    waitIdle();
    checkOutput("range_gate", int'(gate), 'h01);
    applyStimulus(1'b1, 7'd36, 1'b1, 3'd1, 0);
    waitIdle();
    checkOutput("range_low_gate", int'(gate), 'h03);

    // Panic while in ROM drops the event.
    resetDut();
    applyStimulus(1'b1, 7'd41, 1'b1, 3'd0, 5);
    waitIdle();
    acceptEvent(1'b1, 7'd40);
    @(posedge clk); #1 all_off = 1'b1;
    @(posedge clk); #1 all_off = 1'b0;
    checkOutput("alloff_gate", int'(gate), 0);
    checkOutput("alloff_len_wr", int'(len_wr), 0);
    checkOutput("alloff_ev_ready", int'(ev_ready), 1);
    @(posedge clk); #1;
    checkOutput("alloff_len_wr_after", int'(len_wr), 0);

    // Reset while in WRITE clears every output.
    e.voice = 3'd0; e.val = rom_model(6); e.pluck = 8'h01;
    sb_q.push_back(e);
    acceptEvent(1'b1, 7'd42);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("write_len_wr", int'(len_wr), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    checkOutput("wrst_gate", int'(gate), 0);
    checkOutput("wrst_pluck", int'(pluck), 0);
    checkOutput("wrst_len_wr", int'(len_wr), 0);
    checkOutput("wrst_len_val", int'(len_val), 0);
    checkOutput("wrst_len_voice", int'(len_voice), 0);
    checkOutput("wrst_rom_addr", int'(rom_addr), 0);
    checkOutput("wrst_ev_ready", int'(ev_ready), 1);

    waitIdle();
    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
